// File: rtl/bubble_sort8.sv
// bubble_sort8
//   Eight-entry capture buffer with a combinational descending sort on its
//   output. While sortit is low one din word per clock shifts into the buffer
//   and dout is zero. While sortit is high the buffer is frozen and dout shows
//   all eight entries sorted, largest in the top slot.
//
// Ports
//   clk     in   1             rising-edge clock for all state
//   resetn  in   1             asynchronous reset, ACTIVE HIGH (1 = in reset)
//   din     in   BITWIDTH      word captured when sortit = 0
//   sortit  in   1             1 = hold buffer and present sorted data
//   dout    out  8*BITWIDTH    slot k at [k*BITWIDTH +: BITWIDTH]; slot 7 = largest;
//                              all-zero while sortit = 0
module bubble_sort8 #(
  parameter int BITWIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [BITWIDTH-1:0]   din,
  input  logic                  sortit,
  output logic [8*BITWIDTH-1:0] dout
);

  localparam int N = 8;

  logic [BITWIDTH-1:0] mem_q [N];
  logic [BITWIDTH-1:0] mem_d [N];

  // Sort scratch: index 0 ends up holding the largest value.
  logic [BITWIDTH-1:0] sort_w [N];
  logic [BITWIDTH-1:0] swap_tmp;

  // Next-state: shift in din unless frozen.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    if (!sortit) begin
      mem_d[0] = din;
      for (int i = 1; i < N; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // The name says "n" but this reset is active high.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      // NOTE: this is an 8-word register file built from flops, not a RAM macro,
      // so clearing every entry on reset is legal and cheap enough here.
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking for state so all entries shift off the same old values.
      mem_q <= mem_d;
    end
  end

  // Bubble sort, 28 compare-exchange stages. Smaller values sink toward the
  // high index, so after the passes sort_w[0] is the maximum.
  always_comb begin
    sort_w   = mem_q;
    swap_tmp = '0;
    for (int pass = 0; pass < N - 1; pass++) begin
      for (int j = 0; j < N - 1 - pass; j++) begin
        if (sort_w[j] < sort_w[j+1]) begin
          swap_tmp    = sort_w[j];
          sort_w[j]   = sort_w[j+1];
          sort_w[j+1] = swap_tmp;
        end
      end
    end
  end

  // Slot k takes the (7-k)-th largest so slot 7 carries the maximum.
  always_comb begin
    dout = '0;
    if (sortit) begin
      for (int k = 0; k < N; k++) begin
        dout[k*BITWIDTH +: BITWIDTH] = sort_w[N-1-k];
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort8.sv
// tb_bubble_sort8
//   Directed plus short random stimulus for bubble_sort8. A reference buffer
//   tracks captures; expected dout comes either from literal values or from a
//   counting sort over that buffer, pushed to a scoreboard queue and popped
//   when dout is sampled (mid low phase, away from the rising edge).
module tb_bubble_sort8;

  localparam int W = 3;

  logic           clk;
  logic           resetn;
  logic [W-1:0]   din;
  logic           sortit;
  logic [8*W-1:0] dout;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8*W-1:0] exp_q [$];
  string          tag_q [$];

  logic [W-1:0]   model [8];

  bubble_sort8 #(.BITWIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .sortit (sortit),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting sort: walk values from max to min, fill slots from 7 downward.
  function automatic logic [8*W-1:0] model_sorted();
    logic [8*W-1:0] r;
    int pos;
    r = '0;
    pos = 0;
    for (int v = (1 << W) - 1; v >= 0; v--) begin
      for (int i = 0; i < 8; i++) begin
        if (int'(model[i]) == v) begin
          r[(7 - pos)*W +: W] = W'(v);
          pos++;
        end
      end
    end
    return r;
  endfunction

  task automatic expect_out(input string tag, input logic [8*W-1:0] value);
    exp_q.push_back(value);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [8*W-1:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests_run++;
    assert (dout === e) else begin
      tests_failed++;
      $error("FAIL %s: dout=%h expected=%h", t, dout, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // Drive one word with sortit low; dout must read zero during capture.
  task automatic capture(input logic [W-1:0] w);
    @(negedge clk);
    sortit = 1'b0;
    din    = w;
    #1;
    expect_out("capture_zero", '0);
    check_out();
    @(posedge clk);
    for (int i = 7; i > 0; i--) model[i] = model[i-1];
    model[0] = w;
  endtask

  task automatic show_sorted(input string tag);
    @(negedge clk);
    sortit = 1'b1;
    #1;
    expect_out(tag, model_sorted());
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    resetn = 1'b0;
  endtask

  logic [8*W-1:0] frozen;
  logic [W-1:0]   load2 [8];
  logic [W-1:0]   frz [4];

  initial begin
    resetn = 1'b1;
    sortit = 1'b1;
    din    = 3'd7;
    model_clear();

    // Reset held over several edges with sortit high and din = 7.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_out("reset_hold", '0);
      check_out();
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    expect_out("post_reset_mem_zero", '0);
    check_out();

    // Full load.
    load2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd4, 3'd1};
    for (int i = 0; i < 8; i++) capture(load2[i]);
    @(negedge clk);
    sortit = 1'b1;
    #1;
    expect_out("full_load", {3'd7, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1});
    check_out();
    frozen = {3'd7, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1};

    // Freeze: din changes are ignored while sortit is high.
    frz = '{3'd0, 3'd2, 3'd7, 3'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din = frz[i];
      #1;
      expect_out("freeze_hold", frozen);
      check_out();
    end
    @(negedge clk);
    sortit = 1'b0;
    #1;
    expect_out("freeze_drop_zero", '0);
    check_out();
    sortit = 1'b1;  // back up before any rising edge: still no capture
    #1;
    expect_out("freeze_restore", frozen);
    check_out();

    // Reset pulse mid-cycle while sorting.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    expect_out("reset_mid_sort", '0);
    check_out();
    resetn = 1'b0;
    model_clear();
    #1;
    expect_out("after_reset_mid_sort", '0);
    check_out();

    // Partial load.
    capture(3'd3);
    capture(3'd6);
    @(negedge clk);
    sortit = 1'b1;
    #1;
    expect_out("partial_load", {3'd6, 3'd3, 18'd0});
    check_out();

    // Overflow: the leading 7 is evicted.
    do_reset();
    capture(3'd7);
    for (int i = 0; i < 8; i++) capture(3'd1);
    @(negedge clk);
    sortit = 1'b1;
    #1;
    expect_out("overflow", {8{3'd1}});
    check_out();

    // Random loads with interleaved sorts.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) capture(W'($urandom_range(0, 7)));
      show_sorted("random_sort");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
